// File: rtl/encode_disp_pkg.sv
// Shared digit encoding and 7-segment glyph table for the encoder display path.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package encode_disp_pkg;

    localparam int DIGITS = 4;

    typedef logic [3:0] digit_t;

    localparam digit_t DIG_DASH  = 4'hA;
    localparam digit_t DIG_BLANK = 4'hF;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Codes 4'hB..4'hE never occur; they fall back to blank.
    function automatic logic [6:0] seg_decode(input digit_t d);
        logic [6:0] s;
        case (d)
            4'd0:     s = SEG_0;
            4'd1:     s = SEG_1;
            4'd2:     s = SEG_2;
            4'd3:     s = SEG_3;
            4'd4:     s = SEG_4;
            4'd5:     s = SEG_5;
            4'd6:     s = SEG_6;
            4'd7:     s = SEG_7;
            4'd8:     s = SEG_8;
            4'd9:     s = SEG_9;
            DIG_DASH: s = SEG_DASH;
            default:  s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/encode_disp_scan_if.sv
// Encoder-side inputs and board-pin/status outputs of the display scanner.
// master = encoder/board side, slave = the scanner itself.
interface encode_disp_scan_if;
    logic [2:0] D;
    logic       ET;
    logic       disp_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] code_q;
    logic       code_valid;
    logic [7:0] chg_cnt;

    modport master (
        output D, ET, disp_en,
        input  an, seg, dp, code_q, code_valid, chg_cnt
    );

    modport slave (
        input  D, ET, disp_en,
        output an, seg, dp, code_q, code_valid, chg_cnt
    );
endinterface

// File: rtl/code_stabilizer.sv
// Two-flop synchroniser, ET-based normalisation and stability filter for {ET,D}.
// o_accept is high for the single cycle in which the candidate is committed.
module code_stabilizer #(
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] i_d,
    input  logic       i_et,
    output logic [2:0] o_code,
    output logic       o_valid,
    output logic       o_accept,
    output logic [2:0] o_new_code,
    output logic       o_new_valid
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] STAB_TC = CW'(STABLE_CYCLES - 1);

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_cand;
    logic [3:0]    r_acc;
    logic [CW-1:0] r_stab;

    logic [3:0] w_sample;
    logic       w_at_tc;
    logic       w_accept;

    // With no request active the code is meaningless, so collapse it to one value.
    assign w_sample = r_sync2[3] ? r_sync2 : 4'b0000;
    assign w_at_tc  = (r_stab == STAB_TC);
    assign w_accept = (w_sample == r_cand) && w_at_tc && (r_cand != r_acc);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
            r_cand  <= 4'b0000;
            r_acc   <= 4'b0000;
            r_stab  <= '0;
        end else begin
            r_sync1 <= {i_et, i_d};
            r_sync2 <= r_sync1;
            if (w_sample != r_cand) begin
                r_cand <= w_sample;
                r_stab <= '0;
            end else if (!w_at_tc) begin
                r_stab <= r_stab + 1'b1;
            end
            if (w_accept) begin
                r_acc <= r_cand;
            end
        end
    end

    assign o_code      = r_acc[2:0];
    assign o_valid     = r_acc[3];
    assign o_accept    = w_accept;
    assign o_new_code  = r_cand[2:0];
    assign o_new_valid = r_cand[3];

endmodule

// File: rtl/encode_disp_scan.sv
// Encoder-code display: filtered current code, previous valid code and a BCD count of
// accepted valid codes, multiplexed onto a 4-digit common-anode 7-segment display.
module encode_disp_scan
    import encode_disp_pkg::*;
#(
    parameter int REFRESH_DIV   = 50000,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 n_rst,
    encode_disp_scan_if.slave    bus
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [RW-1:0] REFRESH_TC = RW'(REFRESH_DIV - 1);

    logic [2:0] w_code;
    logic       w_valid;
    logic       w_accept;
    logic [2:0] w_new_code;
    logic       w_new_valid;
    digit_t     w_digit;

    logic [RW-1:0]     r_refresh;
    logic [IW-1:0]     r_idx;
    digit_t            r_prev;
    logic [3:0]        r_ones;
    logic [3:0]        r_tens;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;

    code_stabilizer #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stab (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_d         (bus.D),
        .i_et        (bus.ET),
        .o_code      (w_code),
        .o_valid     (w_valid),
        .o_accept    (w_accept),
        .o_new_code  (w_new_code),
        .o_new_valid (w_new_valid)
    );

    always_comb begin
        w_digit = DIG_BLANK;
        case (r_idx)
            2'd0:    w_digit = w_valid ? {1'b0, w_code} : DIG_DASH;
            2'd1:    w_digit = r_prev;
            2'd2:    w_digit = r_ones;
            default: w_digit = r_tens;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_prev    <= DIG_BLANK;
            r_ones    <= 4'd0;
            r_tens    <= 4'd0;
            r_an      <= '1;
            r_seg     <= SEG_BLANK;
        end else begin
            if (r_refresh == REFRESH_TC) begin
                r_refresh <= '0;
                r_idx     <= r_idx + 1'b1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end

            // Old accepted value is still on w_code/w_valid during the accept cycle.
            if (w_accept && w_valid) begin
                r_prev <= {1'b0, w_code};
            end

            if (w_accept && w_new_valid) begin
                if (r_ones == 4'd9) begin
                    r_ones <= 4'd0;
                    r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 1'b1;
                end else begin
                    r_ones <= r_ones + 1'b1;
                end
            end

            if (bus.disp_en) begin
                r_an  <= ~(DIGITS'(1) << r_idx);
                r_seg <= seg_decode(w_digit);
            end else begin
                r_an  <= '1;
                r_seg <= SEG_BLANK;
            end
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = 1'b1;
    assign bus.code_q     = w_code;
    assign bus.code_valid = w_valid;
    assign bus.chg_cnt    = {r_tens, r_ones};

endmodule
